// File: rtl/imm_extend_pipe.sv
// Immediate extender feeding a DEPTH-entry result FIFO with valid/ready on both sides.
// Results are extended at push time; the FIFO head drives data_o one cycle after the push.
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [IN_W-1:0]          data_i,
    input  logic [1:0]               mode_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [OUT_W-1:0]         data_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int          AW      = $clog2(DEPTH);
    localparam logic [AW:0] FULL    = (AW+1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = (AW)'(1);

    function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] imm,
                                                input logic [1:0]      mode);
        logic signed [IN_W-1:0]  imm_s;
        logic signed [OUT_W-1:0] sext;
        imm_s = imm;
        sext  = OUT_W'(imm_s);
        case (mode)
            2'b00:   extend = sext;
            2'b01:   extend = {{(OUT_W-IN_W){1'b0}}, imm};
            2'b10:   extend = {imm, {(OUT_W-IN_W){1'b0}}};
            // Branch offset: word-aligned, top two sign bits fall off.
            default: extend = sext <<< 2;
        endcase
    endfunction

    logic [OUT_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_r;
    logic [OUT_W-1:0] ext_p0;
    logic             vld_p0;
    logic             pop;

    // Stage p0: extend and qualify the incoming immediate
    assign ext_p0  = extend(data_i, mode_i);
    assign vld_p0  = valid_i && ready_o;
    assign pop     = valid_o && ready_i;

    assign ready_o = (count_r < FULL);
    assign valid_o = (count_r != '0);
    assign data_o  = mem[rd_ptr];
    assign count_o = count_r;

    // Stage p1: result buffer; flush wins over any push/pop in the same cycle
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_r <= '0;
        end else begin
            if (vld_p0) begin
                mem[wr_ptr] <= ext_p0;
                wr_ptr      <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({vld_p0, pop})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Scoreboard bench for imm_extend_pipe: directed pushes queue hand-computed results,
// a negedge monitor pops and compares every completed output transfer.
module tb_imm_extend_pipe;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        valid_i;
    logic        ready_o;
    logic [15:0] data_i;
    logic [1:0]  mode_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] data_o;
    logic [2:0]  count_o;

    int n_cmp  = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];

    imm_extend_pipe #(.IN_W(16), .OUT_W(32), .DEPTH(4)) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .mode_i  (mode_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .count_o (count_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: sim time exceeded, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: a transfer completes at the next posedge when valid_o && ready_i
    always @(negedge clk_i) begin
        if (rst_i && !flush_i && valid_o && ready_i) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_output: got 0x%08h, required no output", data_o);
            end else begin
                chk("scoreboard_data", data_o, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic [15:0] d, input logic [1:0] m,
                         input logic [31:0] exp, input bit accept);
        valid_i = 1'b1;
        data_i  = d;
        mode_i  = m;
        if (accept) exp_q.push_back(exp);
        tick();
    endtask

    task automatic idle();
        valid_i = 1'b0;
        data_i  = '0;
        mode_i  = '0;
    endtask

    typedef struct {
        logic [15:0] d;
        logic [1:0]  m;
        logic [31:0] e;
    } vec_t;

    vec_t mode_vecs[5] = '{
        '{16'h8000, 2'b00, 32'hFFFF8000},
        '{16'h8000, 2'b01, 32'h00008000},
        '{16'h1234, 2'b10, 32'h12340000},
        '{16'hFFFF, 2'b11, 32'hFFFFFFFC},
        '{16'h0001, 2'b11, 32'h00000004}
    };

    initial begin
        rst_i   = 1'b0;
        flush_i = 1'b0;
        ready_i = 1'b0;
        idle();
        #2;
        chk("reset_count", 32'(count_o), 32'd0);
        chk("reset_valid", 32'(valid_o), 32'd0);
        chk("reset_ready", 32'(ready_o), 32'd1);
        chk("reset_data",  data_o, 32'd0);
        tick();
        tick();
        rst_i = 1'b1;
        tick();

        // Mode check, streaming with ready_i=1 (count holds at 1)
        ready_i = 1'b1;
        issue(mode_vecs[0].d, mode_vecs[0].m, mode_vecs[0].e, 1'b1);
        chk("latency_valid", 32'(valid_o), 32'd1);
        chk("latency_data",  data_o, 32'hFFFF8000);
        for (int i = 1; i < 5; i++) begin
            issue(mode_vecs[i].d, mode_vecs[i].m, mode_vecs[i].e, 1'b1);
            chk("stream_count", 32'(count_o), 32'd1);
        end
        idle();
        tick();
        chk("mode_drained_count", 32'(count_o), 32'd0);

        // Fill/drain
        ready_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            issue(16'(i), 2'b01, 32'(i), 1'b1);
        end
        chk("fill_ready", 32'(ready_o), 32'd0);
        chk("fill_count", 32'(count_o), 32'd4);
        issue(16'h0005, 2'b01, 32'h5, 1'b0);
        chk("fill_drop_count", 32'(count_o), 32'd4);
        chk("hold_data", data_o, 32'h1);
        idle();
        ready_i = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            tick();
            chk("drain_count", 32'(count_o), 32'(i));
        end
        chk("drain_valid", 32'(valid_o), 32'd0);

        // Concurrent push and pop at count 2
        ready_i = 1'b0;
        issue(16'h7FFF, 2'b00, 32'h00007FFF, 1'b1);
        issue(16'h8001, 2'b00, 32'hFFFF8001, 1'b1);
        ready_i = 1'b1;
        issue(16'h00AB, 2'b10, 32'h00AB0000, 1'b1);
        chk("conc_count", 32'(count_o), 32'd2);
        issue(16'h8000, 2'b11, 32'hFFFE0000, 1'b1);
        chk("conc_count", 32'(count_o), 32'd2);
        issue(16'hFFFF, 2'b01, 32'h0000FFFF, 1'b1);
        chk("conc_count", 32'(count_o), 32'd2);
        idle();
        tick();
        tick();
        chk("conc_drained", 32'(count_o), 32'd0);

        // Full with pop: head leaves, input refused
        ready_i = 1'b0;
        issue(16'h0010, 2'b01, 32'h10, 1'b1);
        issue(16'h0020, 2'b01, 32'h20, 1'b1);
        issue(16'h0030, 2'b01, 32'h30, 1'b1);
        issue(16'h0040, 2'b01, 32'h40, 1'b1);
        ready_i = 1'b1;
        issue(16'h0050, 2'b01, 32'h50, 1'b0);
        chk("full_pop_count", 32'(count_o), 32'd3);
        idle();
        ready_i = 1'b0;
        tick();
        chk("full_pop_ready", 32'(ready_o), 32'd1);
        chk("full_pop_head", data_o, 32'h20);
        ready_i = 1'b1;
        tick();
        tick();
        tick();
        chk("full_pop_drained", 32'(count_o), 32'd0);

        // Flush overrides push and pop
        ready_i = 1'b0;
        issue(16'h0100, 2'b01, 32'h100, 1'b1);
        issue(16'h0200, 2'b01, 32'h200, 1'b1);
        issue(16'h0300, 2'b01, 32'h300, 1'b1);
        chk("preflush_count", 32'(count_o), 32'd3);
        flush_i = 1'b1;
        ready_i = 1'b1;
        issue(16'h0400, 2'b01, 32'h400, 1'b0);
        flush_i = 1'b0;
        exp_q.delete();
        idle();
        chk("flush_count", 32'(count_o), 32'd0);
        chk("flush_valid", 32'(valid_o), 32'd0);
        tick();
        chk("flush_dropped", 32'(count_o), 32'd0);

        // Reset asserted between edges with two entries in flight
        ready_i = 1'b0;
        issue(16'h0AAA, 2'b01, 32'hAAA, 1'b1);
        issue(16'h0BBB, 2'b01, 32'hBBB, 1'b1);
        idle();
        chk("prereset_count", 32'(count_o), 32'd2);
        #2;
        rst_i = 1'b0;
        exp_q.delete();
        #1;
        chk("midreset_valid", 32'(valid_o), 32'd0);
        chk("midreset_count", 32'(count_o), 32'd0);
        chk("midreset_data",  data_o, 32'd0);
        tick();
        #2;
        rst_i = 1'b1;
        tick();
        ready_i = 1'b1;
        issue(16'h00FF, 2'b00, 32'h000000FF, 1'b1);
        chk("post_reset_valid", 32'(valid_o), 32'd1);
        chk("post_reset_data",  data_o, 32'h000000FF);
        idle();
        tick();
        tick();
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        chk("final_count", 32'(count_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_extend_pipe.md
IMM_EXTEND_PIPE -- requirements
Module: imm_extend_pipe

Interface
REQ-001 SHALL have parameter IN_W, default 16, immediate input width in bits.
REQ-002 SHALL have parameter OUT_W, default 32, extended output width; legal only when OUT_W >= IN_W+2.
REQ-003 SHALL have parameter DEPTH, default 4, result buffer entries; legal only when DEPTH is a power of 2 and >= 2.
REQ-004 SHALL have port clk_i, input, 1, the single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_i, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port flush_i, input, 1, synchronous buffer clear.
REQ-007 SHALL have port valid_i, input, 1, input immediate valid.
REQ-008 SHALL have port ready_o, output, 1, block can accept an input this cycle.
REQ-009 SHALL have port data_i, input, IN_W, raw immediate.
REQ-010 SHALL have port mode_i, input, 2, extension mode, sampled with data_i.
REQ-011 SHALL have port valid_o, output, 1, buffer head holds a result.
REQ-012 SHALL have port ready_i, input, 1, consumer accepts the head result.
REQ-013 SHALL have port data_o, output, OUT_W, head result.
REQ-014 SHALL have port count_o, output, log2(DEPTH)+1, buffer occupancy.

Function
REQ-015 SHALL compute mode 00 as sign-extend: {(OUT_W-IN_W) copies of data_i[IN_W-1], data_i}.
REQ-016 SHALL compute mode 01 as zero-extend: {(OUT_W-IN_W) zeros, data_i}.
REQ-017 SHALL compute mode 10 as upper-load: data_i placed at bits [OUT_W-1:OUT_W-IN_W], lower bits zero.
REQ-018 SHALL compute mode 11 as branch offset: the mode-00 value shifted left 2, top 2 bits discarded, bits [1:0] zero.
REQ-019 SHALL accept (push) an input on a rising edge where valid_i=1 and ready_o=1, storing the mode result, not the raw data.
REQ-020 SHALL drive ready_o = (count_o < DEPTH), with no combinational dependence on ready_i or valid_i.
REQ-021 SHALL complete a transfer (pop) on a rising edge where valid_o=1 and ready_i=1, advancing the head.
REQ-022 SHALL give a latency of exactly 1 cycle: a result pushed at edge N is visible at data_o with valid_o=1 after edge N when the buffer was empty; there is no empty-buffer bypass.
REQ-023 SHALL deliver results in strict push order (FIFO).
REQ-024 SHALL drive valid_o = (count_o != 0), and data_o from the head entry; data_o is don't-care when valid_o=0.
REQ-025 SHALL, on a simultaneous push and pop, leave count_o unchanged and keep order intact, including at count_o=1.
REQ-026 SHALL, when full (count_o=DEPTH), ignore valid_i even if ready_i=1 that cycle; the pop still occurs.
REQ-027 SHALL ignore ready_i when empty; count_o never underflows.
REQ-028 SHALL wrap read/write pointers modulo DEPTH.
REQ-029 SHALL, on flush_i=1, set count_o=0 and both pointers to 0 at the next edge, overriding any push or pop that cycle.
REQ-030 SHALL hold data_o and count_o stable while valid_o=1 and ready_i=0, with no push.

Reset
REQ-031 SHALL, on rst_i=0, asynchronously clear count_o=0, both pointers=0, valid_o=0, ready_o=1, regardless of clock.
REQ-032 SHALL reset buffer storage to zero, so data_o=0 during reset.
REQ-033 SHALL discard all in-flight entries when reset is asserted mid-operation, and resume accepting input on the first edge after rst_i returns to 1.

Verification
REQ-034 SHALL pass mode check (defaults, ready_i=1): 0x8000/00 -> 0xFFFF8000; 0x8000/01 -> 0x00008000; 0x1234/10 -> 0x12340000; 0xFFFF/11 -> 0xFFFFFFFC; 0x0001/11 -> 0x00000004.
REQ-035 SHALL pass fill/drain: ready_i=0, push 0x0001..0x0005 mode 01 back-to-back -> ready_o=0 and count_o=4 after the 4th, 0x0005 dropped; ready_i=1 -> outputs 0x1,0x2,0x3,0x4 on consecutive cycles, then valid_o=0.
REQ-036 SHALL pass concurrency: count_o=2, push and pop in the same cycle for 3 cycles -> count_o stays 2, output order matches push order.
REQ-037 SHALL pass full with pop: count_o=4, valid_i=1, ready_i=1 -> head pops, input not accepted, count_o=3 next cycle.
REQ-038 SHALL pass flush: count_o=3, flush_i=1 with valid_i=1 and ready_i=1 -> next cycle count_o=0, valid_o=0, input dropped.
REQ-039 SHALL pass mid-operation reset: count_o=2, rst_i=0 between edges -> valid_o=0 and count_o=0 immediately; after release, a push of 0x00FF/00 yields 0x000000FF one cycle later.
